// File: rtl/scramble_gen.sv
// Scramble sequencer: issues NUM_MOVES pseudo-random face turns, one per accepted tick, over valid/ready.
// Define SCRAMBLE_NO_REPEAT_EN to also reject a turn on the same face as the previous one.
module scramble_gen #(
    parameter int          NUM_MOVES = 20,
    parameter int          CNT_W     = 5,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic             move_ready,
    output logic             move_valid,
    output logic [2:0]       move_face,
    output logic             move_dir,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] moves_left
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        ISSUE     = 2'd2
    } state_t;

    localparam logic [15:0] TAPS = 16'hB400;

    state_t           state_reg, state_next;
    logic [15:0]      lfsr_reg, lfsr_next, lfsr_step;
    logic [2:0]       face_reg, face_next;
    logic [2:0]       last_face_reg, last_face_next;
    logic             dir_reg, dir_next;
    logic [CNT_W-1:0] moves_left_reg, moves_left_next;
    logic             done_reg, done_next;
    logic [2:0]       cand_face;
    logic             cand_dir;
    logic             cand_ok;

    // Galois step: shift right, fold the outgoing bit back into the tap positions.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_lfsr
            if (gi == 15) begin : g_top
                assign lfsr_step[gi] = lfsr_reg[0] & TAPS[gi];
            end else begin : g_mid
                assign lfsr_step[gi] = lfsr_reg[gi+1] ^ (lfsr_reg[0] & TAPS[gi]);
            end
        end
    endgenerate

    assign cand_face = lfsr_step[2:0];
    assign cand_dir  = lfsr_step[3];

`ifdef SCRAMBLE_NO_REPEAT_EN
    assign cand_ok = (cand_face < 3'd6) && (cand_face != last_face_reg);
`else
    assign cand_ok = (cand_face < 3'd6);
`endif

    always_comb begin
        state_next      = state_reg;
        lfsr_next       = lfsr_reg;
        face_next       = face_reg;
        dir_next        = dir_reg;
        last_face_next  = last_face_reg;
        moves_left_next = moves_left_reg;
        done_next       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    moves_left_next = CNT_W'(NUM_MOVES);
                    last_face_next  = 3'd7;
                    state_next      = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (tick) begin
                    lfsr_next = lfsr_step;
                    if (cand_ok) begin
                        face_next  = cand_face;
                        dir_next   = cand_dir;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (move_ready) begin
                    last_face_next  = face_reg;
                    moves_left_next = moves_left_reg - CNT_W'(1);
                    if (moves_left_reg == CNT_W'(1)) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = WAIT_TICK;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            lfsr_reg       <= LFSR_SEED;
            face_reg       <= 3'd0;
            dir_reg        <= 1'b0;
            last_face_reg  <= 3'd7;
            moves_left_reg <= '0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            lfsr_reg       <= lfsr_next;
            face_reg       <= face_next;
            dir_reg        <= dir_next;
            last_face_reg  <= last_face_next;
            moves_left_reg <= moves_left_next;
            done_reg       <= done_next;
        end
    end

    assign move_valid = (state_reg == ISSUE);
    assign move_face  = face_reg;
    assign move_dir   = dir_reg;
    assign busy       = (state_reg != IDLE);
    assign done       = done_reg;
    assign moves_left = moves_left_reg;

endmodule

// File: tb/tb_scramble_gen.sv
// Directed bench for scramble_gen: main instance with NUM_MOVES=20, second instance with NUM_MOVES=3.
// Expected faces follow the LFSR walk from ACE1: E270,7138,389C,1C4E,0E27,B313,ED89,...
module tb_scramble_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0, start = 1'b0, move_ready = 1'b0;
    logic       move_valid, move_dir, busy, done;
    logic [2:0] move_face;
    logic [4:0] moves_left;

    logic       tick3 = 1'b0, start3 = 1'b0;
    logic       ready3 = 1'b1;
    logic       move_valid3, move_dir3, busy3, done3;
    logic [2:0] move_face3;
    logic [4:0] moves_left3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    scramble_gen dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .move_ready(move_ready),
        .move_valid(move_valid), .move_face(move_face), .move_dir(move_dir),
        .busy(busy), .done(done), .moves_left(moves_left)
    );

    scramble_gen #(.NUM_MOVES(3)) dut3 (
        .clk(clk), .rst(rst), .tick(tick3), .start(start3), .move_ready(ready3),
        .move_valid(move_valid3), .move_face(move_face3), .move_dir(move_dir3),
        .busy(busy3), .done(done3), .moves_left(moves_left3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

`ifdef SCRAMBLE_NO_REPEAT_EN
    localparam int LEFT_AFTER_HOLD = 18;
    logic [2:0] exp3 [3] = '{3'd0, 3'd4, 3'd3};
`else
    localparam int LEFT_AFTER_HOLD = 17;
    logic [2:0] exp3 [3] = '{3'd0, 3'd0, 3'd4};
`endif

    // Monitor for the short-scramble instance; one line per accepted move.
    int   hs_count   = 0;
    int   done_count = 0;
    int   done_run   = 0;
    int   done_max   = 0;
    logic busy3_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (move_valid3 && ready3) begin
                $display("move %0d: face %0d dir %0d", hs_count, move_face3, move_dir3);
                check("run_face_legal", 32'(move_face3 <= 3'd5), 32'd1);
                if (hs_count < 3)
                    check("run_face_seq", 32'(move_face3), 32'(exp3[hs_count]));
                hs_count <= hs_count + 1;
            end
            if (done3) begin
                check("done_busy_low", 32'(busy3), 32'd0);
                check("done_busy_fell", 32'(busy3_prev), 32'd1);
                check("done_left_zero", 32'(moves_left3), 32'd0);
                done_count <= done_count + 1;
                done_run   <= done_run + 1;
                if (done_run + 1 > done_max) done_max <= done_run + 1;
            end else begin
                done_run <= 0;
            end
            busy3_prev <= busy3;
        end
    end

    initial begin
        int bad;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(move_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_left", 32'(moves_left), 32'd0);
        check("rst_face", 32'(move_face), 32'd0);
        rst = 1'b0;
        step();

        // Tick in IDLE must not step the LFSR.
        tick = 1'b1; step(); tick = 1'b0;
        check("idle_tick_busy", 32'(busy), 32'd0);
        start = 1'b1; step(); start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_left", 32'(moves_left), 32'd20);
        check("start_valid", 32'(move_valid), 32'd0);

        tick = 1'b1; step(); tick = 1'b0;
        check("m1_valid", 32'(move_valid), 32'd1);
        check("m1_face", 32'(move_face), 32'd0);
        check("m1_dir", 32'(move_dir), 32'd0);
        move_ready = 1'b1; step(); move_ready = 1'b0;
        check("m1_left", 32'(moves_left), 32'd19);
        check("m1_valid_drop", 32'(move_valid), 32'd0);

        tick = 1'b1; step(); tick = 1'b0;
`ifdef SCRAMBLE_NO_REPEAT_EN
        check("m2_rejected", 32'(move_valid), 32'd0);
        step();
        check("m2_still_wait", 32'(move_valid), 32'd0);
`else
        check("m2_valid", 32'(move_valid), 32'd1);
        check("m2_face", 32'(move_face), 32'd0);
        check("m2_dir", 32'(move_dir), 32'd1);
        move_ready = 1'b1; step(); move_ready = 1'b0;
        check("m2_left", 32'(moves_left), 32'd18);
`endif

        tick = 1'b1; step(); tick = 1'b0;
        check("m3_valid", 32'(move_valid), 32'd1);
        check("m3_face", 32'(move_face), 32'd4);
        check("m3_dir", 32'(move_dir), 32'd1);

        // Stall 50 cycles with ticks arriving in ISSUE.
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick = (i % 10 == 5);
            step();
            if (move_valid !== 1'b1 || move_face !== 3'd4 || move_dir !== 1'b1) bad++;
        end
        tick = 1'b0;
        check("hold_stable", 32'(bad), 32'd0);
        move_ready = 1'b1; step(); move_ready = 1'b0;
        check("hold_left", 32'(moves_left), 32'(LEFT_AFTER_HOLD));
        check("hold_valid_drop", 32'(move_valid), 32'd0);

        // Faces 6 and 7 rejected, then 3: proves stall ticks left the LFSR alone.
        tick = 1'b1; step(); tick = 1'b0;
        check("rej6_valid", 32'(move_valid), 32'd0);
        tick = 1'b1; step(); tick = 1'b0;
        check("rej7_valid", 32'(move_valid), 32'd0);
        tick = 1'b1; step(); tick = 1'b0;
        check("m4_valid", 32'(move_valid), 32'd1);
        check("m4_face", 32'(move_face), 32'd3);
        check("m4_dir", 32'(move_dir), 32'd0);
        move_ready = 1'b1; step(); move_ready = 1'b0;

        start = 1'b1; step(); start = 1'b0;
        check("busy_start_left", 32'(moves_left), 32'(LEFT_AFTER_HOLD - 1));
        check("busy_start_valid", 32'(move_valid), 32'd0);

        tick = 1'b1; step(); tick = 1'b0;
        check("m5_valid", 32'(move_valid), 32'd1);
        check("m5_face", 32'(move_face), 32'd1);
        check("m5_dir", 32'(move_dir), 32'd1);

        // Asynchronous reset between clock edges.
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(move_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_left", 32'(moves_left), 32'd0);
        check("arst_face", 32'(move_face), 32'd0);
        check("arst_dir", 32'(move_dir), 32'd0);
        step();
        rst = 1'b0;
        step();

        start = 1'b1; tick = 1'b1; step(); start = 1'b0; tick = 1'b0;
        check("st_busy", 32'(busy), 32'd1);
        check("st_left", 32'(moves_left), 32'd20);
        check("st_valid", 32'(move_valid), 32'd0);
        step();
        check("st_valid_later", 32'(move_valid), 32'd0);
        tick = 1'b1; step(); tick = 1'b0;
        check("re_valid", 32'(move_valid), 32'd1);
        check("re_face", 32'(move_face), 32'd0);
        check("re_dir", 32'(move_dir), 32'd0);

        // Full three-move scramble on the second instance.
        start3 = 1'b1; step(); start3 = 1'b0;
        check("run_start_left", 32'(moves_left3), 32'd3);
        for (int t = 0; t < 20 && done_count == 0; t++) begin
            repeat (9) step();
            tick3 = 1'b1; step(); tick3 = 1'b0;
        end
        repeat (5) step();
        check("run_handshakes", 32'(hs_count), 32'd3);
        check("run_done_pulses", 32'(done_count), 32'd1);
        check("run_done_width", 32'(done_max), 32'd1);
        check("run_end_busy", 32'(busy3), 32'd0);
        check("run_end_left", 32'(moves_left3), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
